// File: rtl/fw_car_sensor.sv
// Farm-way loop detector front end: synchronizes and debounces the loop level,
// keeps a saturating count of waiting cars and flags a loop stuck occupied.
module fw_car_sensor #(
  parameter int DEB_CYC   = 4,
  parameter int STUCK_CYC = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_sense,
  input  logic       car_served,
  output logic       car_on_fw,
  output logic [3:0] car_count,
  output logic       sensor_fault
);

  typedef enum logic [1:0] {
    IDLE,
    QUAL_ON,
    PRESENT,
    QUAL_OFF
  } state_t;

  localparam logic [3:0] DEB_LAST  = 4'(DEB_CYC - 1);
  localparam logic [9:0] STUCK_LIM = 10'(STUCK_CYC);
  localparam logic [9:0] STUCK_MAX = 10'h3FF;

  logic       sync1;
  logic       s;
  state_t     state;
  state_t     next_state;
  logic [3:0] deb_cnt;
  logic [3:0] deb_next;
  logic [9:0] stuck_cnt;
  logic [9:0] stuck_next;
  logic       arrival;
  logic       occupied;
  logic       fault_next;
  logic [3:0] count_next;

  // raw_sense is asynchronous to clk; only this pair of flops may look at it
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw_sense;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      deb_cnt      <= '0;
      stuck_cnt    <= '0;
      car_count    <= '0;
      sensor_fault <= 1'b0;
    end else begin
      state        <= next_state;
      deb_cnt      <= deb_next;
      stuck_cnt    <= stuck_next;
      car_count    <= count_next;
      sensor_fault <= fault_next;
    end
  end

  always_comb begin
    next_state = state;
    deb_next   = deb_cnt;
    arrival    = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          next_state = QUAL_ON;
          deb_next   = 4'd1;
        end else begin
          deb_next   = '0;
        end
      end
      QUAL_ON: begin
        if (!s) begin
          next_state = IDLE;
          deb_next   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          next_state = PRESENT;
          deb_next   = '0;
          arrival    = 1'b1;
        end else begin
          deb_next   = deb_cnt + 4'd1;
        end
      end
      PRESENT: begin
        if (!s) begin
          next_state = QUAL_OFF;
          deb_next   = 4'd1;
        end
      end
      QUAL_OFF: begin
        if (s) begin
          next_state = PRESENT;
          deb_next   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          next_state = IDLE;
          deb_next   = '0;
        end else begin
          deb_next   = deb_cnt + 4'd1;
        end
      end
      default: begin
        next_state = IDLE;
        deb_next   = '0;
      end
    endcase
  end

  // The fault persists through short dropouts and only clears once the loop
  // has been fully qualified as empty again
  always_comb begin
    occupied   = (state == PRESENT) || (state == QUAL_OFF);
    stuck_next = '0;
    if (occupied) begin
      stuck_next = (stuck_cnt == STUCK_MAX) ? stuck_cnt : stuck_cnt + 10'd1;
    end
    fault_next = sensor_fault;
    if (next_state == IDLE) begin
      fault_next = 1'b0;
    end else if (occupied && (stuck_next == STUCK_LIM)) begin
      fault_next = 1'b1;
    end
  end

  always_comb begin
    count_next = car_count;
    if (arrival && !car_served) begin
      if (car_count != 4'd15) begin
        count_next = car_count + 4'd1;
      end
    end else if (car_served && !arrival) begin
      if (car_count != 4'd0) begin
        count_next = car_count - 4'd1;
      end
    end
  end

  assign car_on_fw = (car_count != 4'd0) || sensor_fault;

endmodule

// File: doc/fw_car_sensor.md
FW_CAR_SENSOR -- requirements
Module: fw_car_sensor

Interface
REQ-001 SHALL have parameter DEB_CYC, default 4: consecutive synchronized samples needed to accept a level change (legal 2..15).
REQ-002 SHALL have parameter STUCK_CYC, default 200: cycles of continuous presence before a fault is flagged (legal DEB_CYC+1..1023).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port raw_sense, input, 1, unsynchronized loop-detector level; 1 means a vehicle is over the farm-way loop.
REQ-006 SHALL have port car_served, input, 1, single-cycle pulse from the farm-way controller meaning one waiting car has passed.
REQ-007 SHALL have port car_on_fw, output, 1, qualified farm-way request consumed by the farm-way and highway controllers.
REQ-008 SHALL have port car_count, output, 4, number of waiting cars, saturating.
REQ-009 SHALL have port sensor_fault, output, 1, loop stuck-occupied indication.

Function
REQ-010 SHALL pass raw_sense through a two-flop synchronizer; the second flop output is "s"; no other logic SHALL sample raw_sense.
REQ-011 SHALL implement FSM states IDLE, QUAL_ON, PRESENT, QUAL_OFF with a debounce counter deb_cnt (4 bits).
REQ-012 IDLE: s=1 -> QUAL_ON, deb_cnt=1; s=0 -> stay, deb_cnt=0.
REQ-013 QUAL_ON: s=0 -> IDLE, deb_cnt=0; s=1 and deb_cnt<DEB_CYC-1 -> deb_cnt+1; s=1 and deb_cnt=DEB_CYC-1 -> PRESENT, deb_cnt=0, arrival event.
REQ-014 PRESENT: s=0 -> QUAL_OFF, deb_cnt=1; s=1 -> stay.
REQ-015 QUAL_OFF: s=1 -> PRESENT, deb_cnt=0; s=0 and deb_cnt<DEB_CYC-1 -> deb_cnt+1; s=0 and deb_cnt=DEB_CYC-1 -> IDLE, deb_cnt=0.
REQ-016 Net effect: arrival event occurs on the edge that is the DEB_CYC-th consecutive edge sampling s=1; car_count updates on that same edge.
REQ-017 Arrival only -> car_count+1, saturating at 15; car_served only -> car_count-1, saturating at 0; both on the same edge -> car_count unchanged (including when car_count is 15 or 0).
REQ-018 car_served while car_count=0 SHALL be ignored, with no error indication.
REQ-019 A stuck counter (10 bits) SHALL increment every cycle in PRESENT or QUAL_OFF, saturating, and clear to 0 in IDLE and QUAL_ON.
REQ-020 sensor_fault SHALL be set on the edge where the stuck counter reaches STUCK_CYC, and SHALL remain set until the FSM enters IDLE; it clears on that same edge.
REQ-021 car_on_fw SHALL equal (car_count != 0) OR sensor_fault, decoded only from registers, so there are no combinational paths from inputs.
REQ-022 Latency: raw_sense first sampled high at edge N and held high -> car_count and car_on_fw update after edge N+DEB_CYC+1.
REQ-023 Glitches shorter than DEB_CYC samples SHALL change neither car_count nor the PRESENT/IDLE status.

Reset
REQ-024 reset=1 at a rising edge SHALL force: synchronizer flops 0, state IDLE, deb_cnt 0, stuck counter 0, car_count 0, sensor_fault 0, and therefore car_on_fw 0.
REQ-025 reset SHALL override car_served and any debounce in progress; a partial qualification SHALL be discarded, not resumed.
REQ-026 After reset deasserts, the FSM SHALL require a full DEB_CYC qualification again, even if raw_sense is already high.

Verification
REQ-027 Nominal arrival: DEB_CYC=4, raw_sense 0->1 sampled at edge 10, held -> car_count=1 and car_on_fw=1 after edge 15; 0 before that edge.
REQ-028 Glitch rejection: raw_sense high for 3 cycles then low -> car_count stays 0 and car_on_fw stays 0 throughout.
REQ-029 Queue arithmetic: 16 qualified arrivals -> car_count=15 (saturated); then 15 car_served pulses -> 0 with car_on_fw=0; one further car_served -> still 0.
REQ-030 Simultaneous events: car_count=3, car_served coincides with the arrival edge -> car_count=3; car_count=15 coincident -> 15.
REQ-031 Stuck sensor: STUCK_CYC=20, raw_sense held high with car_served consumed to car_count=0 -> sensor_fault=1 and car_on_fw=1 exactly 20 cycles after entering PRESENT; raw_sense low for 4 samples -> sensor_fault=0, car_on_fw=0.
REQ-032 Mid-operation reset: reset pulsed while in QUAL_ON with deb_cnt=2 and car_count=5 -> all outputs 0 next edge; raw_sense still high -> arrival only after a fresh DEB_CYC+2 edges (synchronizer refill plus qualification).
